// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the word-granular store buffer.
package store_buffer_pkg;
    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    // Low address bits a word access must carry
    localparam logic [1:0] WORD_ALIGN = 2'b00;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == WORD_ALIGN;
    endfunction
endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side request/response plus data-memory port of the store buffer.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              Startin;
    logic              MemWriteIn;
    logic              MemReadIn;
    logic [ADDR_W-1:0] AddressIn;
    logic [DATA_W-1:0] WriteDataIn;
    logic [DATA_W-1:0] ReadDataOut;
    logic              Stall;
    logic              Misaligned;
    logic              Empty;
    logic              MemReady;
    logic [ADDR_W-1:0] MemAddress;
    logic [DATA_W-1:0] MemWriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] MemReadData;

    // master: pipeline and data memory side; slave: the store buffer
    modport master (
        output Startin, MemWriteIn, MemReadIn, AddressIn, WriteDataIn, MemReady, MemReadData,
        input  ReadDataOut, Stall, Misaligned, Empty, MemAddress, MemWriteData, MemWrite, MemRead
    );
    modport slave (
        input  Startin, MemWriteIn, MemReadIn, AddressIn, WriteDataIn, MemReady, MemReadData,
        output ReadDataOut, Stall, Misaligned, Empty, MemAddress, MemWriteData, MemWrite, MemRead
    );
endinterface

// File: rtl/store_buffer_match.sv
// Load-forwarding lookup: compares every entry against the load address and
// returns the youngest valid hit, where youngest is the slot just behind tail.
module store_buffer_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
    input  logic [PTR_W-1:0]             tail_i,
    input  logic [ADDR_W-1:0]            raddr_i,
    output logic                         hit_o,
    output logic [DATA_W-1:0]            hit_data_o
);
    logic [PTR_W-1:0] idx;

    // Walk from oldest (tail-DEPTH) to youngest (tail-1); later hits override.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail_i - PTR_W'(k);
            if (valid_i[idx] && addr_i[idx] == raddr_i) begin
                hit_o      = 1'b1;
                hit_data_o = data_i[idx];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// Store buffer between EX/MEM and data memory: stores retire into a FIFO and
// drain when the port is free; loads own the port and forward from the FIFO.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]             val_q, val_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    logic              aligned, ld, st, empty, full, drain, stall, enq;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    store_buffer_match #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .PTR_W (PTR_W)
    ) u_match (
        .valid_i   (val_q),
        .addr_i    (addr_q),
        .data_i    (data_q),
        .tail_i    (tail_q),
        .raddr_i   (bus.AddressIn),
        .hit_o     (hit),
        .hit_data_o(hit_data)
    );

    always_comb begin
        aligned = word_aligned(bus.AddressIn[1:0]);
        ld      = bus.MemReadIn && aligned;
        st      = bus.MemWriteIn && aligned;
        empty   = (cnt_q == '0);
        full    = (cnt_q == CNT_W'(DEPTH));
        // Any load request, even a misaligned one, keeps the port for itself.
        drain   = !empty && bus.MemReady && !bus.MemReadIn && !bus.Startin;
        stall   = st && full && !drain && !bus.Startin;
        enq     = st && !stall && !bus.Startin;
    end

    always_comb begin
        bus.Stall        = stall;
        bus.Empty        = empty;
        bus.Misaligned   = (bus.MemReadIn || bus.MemWriteIn) && !aligned;
        bus.MemRead      = ld;
        bus.MemWrite     = drain;
        bus.MemAddress   = '0;
        bus.MemWriteData = '0;
        bus.ReadDataOut  = '0;
        if (ld) begin
            bus.MemAddress  = bus.AddressIn;
            bus.ReadDataOut = hit ? hit_data : bus.MemReadData;
        end else if (drain) begin
            bus.MemAddress   = addr_q[head_q];
            bus.MemWriteData = data_q[head_q];
        end
    end

    always_comb begin
        val_d  = val_q;
        addr_d = addr_q;
        data_d = data_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (bus.Startin) begin
            val_d  = '0;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            // Drain clears first so an enqueue into the same slot when full wins.
            if (drain) begin
                val_d[head_q] = 1'b0;
                head_d        = head_q + 1'b1;
            end
            if (enq) begin
                val_d[tail_q]  = 1'b1;
                addr_d[tail_q] = bus.AddressIn;
                data_d[tail_q] = bus.WriteDataIn;
                tail_d         = tail_q + 1'b1;
            end
            cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(drain);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            val_q  <= val_d;
            addr_q <= addr_d;
            data_q <= data_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven check of the store buffer: forwarding, full stall,
// load priority, misalignment, Startin flush and reset during a drain.
module tb_store_buffer;
    localparam logic [31:0] MRD = 32'h5555_0000;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    store_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st, we, re;
        logic [31:0] addr, wd;
        logic        rdy;
        logic [31:0] rdo;
        logic        stall, mis, emp, mw;
        logic [31:0] maddr, mwd;
        logic        mr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic st, we, re, input logic [31:0] addr, wd,
                                input logic rdy, input logic [31:0] rdo,
                                input logic stall, mis, emp, mw,
                                input logic [31:0] maddr, mwd, input logic mr);
        vec_t v;
        v.st = st; v.we = we; v.re = re; v.addr = addr; v.wd = wd; v.rdy = rdy;
        v.rdo = rdo; v.stall = stall; v.mis = mis; v.emp = emp; v.mw = mw;
        v.maddr = maddr; v.mwd = mwd; v.mr = mr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.Startin     = v.st;
        bus.MemWriteIn  = v.we;
        bus.MemReadIn   = v.re;
        bus.AddressIn   = v.addr;
        bus.WriteDataIn = v.wd;
        bus.MemReady    = v.rdy;
    endtask

    task automatic check(input vec_t v, input string tag);
        chk({tag, ".ReadDataOut"},  bus.ReadDataOut,        v.rdo);
        chk({tag, ".Stall"},        32'(bus.Stall),         32'(v.stall));
        chk({tag, ".Misaligned"},   32'(bus.Misaligned),    32'(v.mis));
        chk({tag, ".Empty"},        32'(bus.Empty),         32'(v.emp));
        chk({tag, ".MemWrite"},     32'(bus.MemWrite),      32'(v.mw));
        chk({tag, ".MemAddress"},   bus.MemAddress,         v.maddr);
        chk({tag, ".MemWriteData"}, bus.MemWriteData,       v.mwd);
        chk({tag, ".MemRead"},      32'(bus.MemRead),       32'(v.mr));
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        check(v, tag);
    endtask

    initial begin
        vec_t idle;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.MemReadData = MRD;
        idle = mk(0,0,0, 32'h0, 32'h0, 0, 32'h0, 0,0,1,0, 32'h0, 32'h0, 0);
        drive(idle);
        #3;
        check(idle, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        //        st we re addr   wd     rdy  rdo     stl mis emp mw maddr  mwd     mr
        // forwarding, misalignment, in-order drain
        vt.push_back(mk(0,1,0, 32'h8,  32'hAAAA,0, 32'h0,    0,0,1,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,1,0, 32'h8,  32'hBBBB,0, 32'h0,    0,0,0,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,0,1, 32'h8,  32'h0,   0, 32'hBBBB, 0,0,0,0, 32'h8,  32'h0,    1));
        vt.push_back(mk(0,0,1, 32'hC,  32'h0,   0, MRD,      0,0,0,0, 32'hC,  32'h0,    1));
        vt.push_back(mk(0,1,0, 32'h6,  32'h1234,0, 32'h0,    0,1,0,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,0,1, 32'h5,  32'h0,   0, 32'h0,    0,1,0,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,0,0, 32'h0,  32'h0,   1, 32'h0,    0,0,0,1, 32'h8,  32'hAAAA, 0));
        vt.push_back(mk(0,0,1, 32'h8,  32'h0,   1, 32'hBBBB, 0,0,0,0, 32'h8,  32'h0,    1));
        vt.push_back(mk(0,0,0, 32'h0,  32'h0,   1, 32'h0,    0,0,0,1, 32'h8,  32'hBBBB, 0));
        vt.push_back(mk(0,0,0, 32'h0,  32'h0,   1, 32'h0,    0,0,1,0, 32'h0,  32'h0,    0));
        // full stall, enqueue+drain on the same edge, load priority
        vt.push_back(mk(0,1,0, 32'h0,  32'h1,   0, 32'h0,    0,0,1,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,1,0, 32'h4,  32'h2,   0, 32'h0,    0,0,0,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,1,0, 32'h8,  32'h3,   0, 32'h0,    0,0,0,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,1,0, 32'hC,  32'h4,   0, 32'h0,    0,0,0,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,1,0, 32'h10, 32'h5,   0, 32'h0,    1,0,0,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,1,0, 32'h10, 32'h5,   1, 32'h0,    0,0,0,1, 32'h0,  32'h1,    0));
        vt.push_back(mk(0,1,0, 32'h14, 32'h6,   0, 32'h0,    1,0,0,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,0,1, 32'h10, 32'h0,   0, 32'h5,    0,0,0,0, 32'h10, 32'h0,    1));
        vt.push_back(mk(0,0,1, 32'h4,  32'h0,   1, 32'h2,    0,0,0,0, 32'h4,  32'h0,    1));
        vt.push_back(mk(0,0,0, 32'h0,  32'h0,   1, 32'h0,    0,0,0,1, 32'h4,  32'h2,    0));
        vt.push_back(mk(0,0,0, 32'h0,  32'h0,   1, 32'h0,    0,0,0,1, 32'h8,  32'h3,    0));
        vt.push_back(mk(0,0,0, 32'h0,  32'h0,   1, 32'h0,    0,0,0,1, 32'hC,  32'h4,    0));
        vt.push_back(mk(0,0,0, 32'h0,  32'h0,   1, 32'h0,    0,0,0,1, 32'h10, 32'h5,    0));
        vt.push_back(mk(0,0,0, 32'h0,  32'h0,   1, 32'h0,    0,0,1,0, 32'h0,  32'h0,    0));
        // Startin flush with a concurrent store
        vt.push_back(mk(0,1,0, 32'h0,  32'hA,   0, 32'h0,    0,0,1,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,1,0, 32'h4,  32'hB,   0, 32'h0,    0,0,0,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,1,0, 32'h8,  32'hC,   0, 32'h0,    0,0,0,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(1,1,0, 32'h20, 32'hD,   1, 32'h0,    0,0,0,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,0,0, 32'h0,  32'h0,   1, 32'h0,    0,0,1,0, 32'h0,  32'h0,    0));
        vt.push_back(mk(0,0,1, 32'h20, 32'h0,   0, MRD,      0,0,1,0, 32'h20, 32'h0,    1));
        vt.push_back(mk(0,0,1, 32'h0,  32'h0,   0, MRD,      0,0,1,0, 32'h0,  32'h0,    1));

        foreach (vt[i]) apply(vt[i], $sformatf("v%0d", i));

        // Reset asserted asynchronously in the middle of a drain cycle
        apply(mk(0,1,0, 32'h0, 32'h11, 0, 32'h0, 0,0,1,0, 32'h0, 32'h0, 0), "rd.s0");
        apply(mk(0,1,0, 32'h4, 32'h22, 0, 32'h0, 0,0,0,0, 32'h0, 32'h0, 0), "rd.s1");
        apply(mk(0,1,0, 32'h8, 32'h33, 0, 32'h0, 0,0,0,0, 32'h0, 32'h0, 0), "rd.s2");
        apply(mk(0,0,0, 32'h0, 32'h0,  1, 32'h0, 0,0,0,1, 32'h0, 32'h11, 0), "rd.drain");
        rst_n = 1'b0;
        #1;
        chk("rd.Empty",        32'(bus.Empty),    32'h1);
        chk("rd.MemWrite",     32'(bus.MemWrite), 32'h0);
        chk("rd.MemAddress",   bus.MemAddress,    32'h0);
        chk("rd.MemWriteData", bus.MemWriteData,  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(0,0,1, 32'h8, 32'h0, 0, MRD, 0,0,1,0, 32'h8, 32'h0, 1), "rd.load");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Word-granular store buffer between the EX/MEM pipeline register and the data memory. Stores from the pipeline retire into a small FIFO in one cycle and drain to memory when the memory port is free. Loads always take the port and see the youngest buffered store to the same word. The pipeline stalls only when the buffer is full and memory cannot accept a write.

## Interface
- DEPTH, 4, number of buffered stores; power of two, ≥2
- ADDR_W, 32, address width
- DATA_W, 32, data width (one memory word)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- Startin  in  1  memory-initialise strobe; also synchronously discards all buffered stores
- MemWriteIn  in  1  store request from EX/MEM
- MemReadIn  in  1  load request from EX/MEM; never asserted together with MemWriteIn
- AddressIn  in  ADDR_W  byte address of the load or store
- WriteDataIn  in  DATA_W  store data
- ReadDataOut  out  DATA_W  load result, valid in the same cycle as MemReadIn
- Stall  out  1  store not accepted this cycle; pipeline must hold
- Misaligned  out  1  AddressIn[1:0]≠0 on a load or store
- Empty  out  1  no buffered stores
- MemReady  in  1  data memory accepts a write this cycle
- MemAddress  out  ADDR_W  to data memory Address
- MemWriteData  out  DATA_W  to data memory WriteData
- MemWrite  out  1  to data memory MemWrite
- MemRead  out  1  to data memory MemRead
- MemReadData  in  DATA_W  from data memory ReadData

## Operation
- State per entry: valid, addr, data. Head and tail pointers wrap modulo DEPTH. A count runs 0..DEPTH.
- full = (count==DEPTH). Empty = (count==0).
- drain = !Empty && MemReady && !MemReadIn && !Startin.
- Drain cycle: MemWrite=1, MemAddress=head.addr, MemWriteData=head.data. The head advances and is invalidated on the edge.
- Load cycle, when MemReadIn is set and the address is aligned:
  - MemRead=1, MemAddress=AddressIn, MemWrite=0.
  - ReadDataOut = data of the youngest valid entry whose addr==AddressIn, otherwise MemReadData.
- Store, when MemWriteIn is set and the address is aligned:
  - Stall = full && !drain.
  - If !Stall, write {AddressIn, WriteDataIn} at tail on the edge.
  - Enqueue and drain in the same cycle leave count unchanged. The drained entry is the old head, never the new one.
- Misaligned load or store:
  - Misaligned=1 combinationally.
  - A misaligned store is dropped, not enqueued, with Stall=0.
  - A misaligned load gives ReadDataOut=0 and MemRead=0.
- Startin=1:
  - On the edge, count, head and tail go to 0 and every valid bit clears.
  - Startin has priority over enqueue and drain.
  - MemWrite=0 and Stall=0 in that cycle.
- Idle (no load, no drain): MemRead=0, MemWrite=0, MemAddress=0, MemWriteData=0, ReadDataOut=0.
- Reset (rst_n low, asynchronous): all valid bits 0, pointers and count 0, Empty=1, Stall=0, all Mem* outputs 0, ReadDataOut=0, Misaligned=0.

## Timing
- Store acceptance: the entry becomes visible to load forwarding in the cycle after the accepting edge.
- Load latency: zero cycles, purely combinational from AddressIn/MemReadData to ReadDataOut.
- Drain: one entry per cycle maximum. The first drain happens one cycle after the enqueue edge, given MemReady=1 and no load.
- Full with MemReady=0: Stall stays high until a cycle with MemReady=1 and no load. The held store then enqueues at that edge.
- Loads indefinitely starve drain. This is acceptable because loads never stall.
- Stall, Misaligned, Empty and all Mem* outputs are combinational from state and the current inputs. There are no registered outputs.
- rst_n deassertion is synchronised by the top level. The block itself only requires rst_n to be stable around clk edges.

## Structure
- Shared package store_buffer_pkg holds:
  - the entry type {valid, addr[ADDR_W], data[DATA_W]}
  - the default DEPTH
  - the word-alignment mask constant (2'b00)
- Sub-module store_buffer_match: DEPTH-way address compare plus youngest-match priority select, relative to tail. Outputs are hit and hit_data.
- The top level holds the entry array, pointers, count, and the port mux.

## Test plan
- Reset mid-drain: fill 3 entries, drop rst_n during a drain cycle. Expected: Empty=1, MemWrite=0 immediately; after release, a load of 0x8 returns MemReadData.
- Forwarding: store 0x8=0xAAAA, then 0x8=0xBBBB, then load 0x8 with MemReady=0. Expected: ReadDataOut=0xBBBB, MemRead=1.
- Full stall: MemReady=0, 5 stores to 0x0,0x4,0x8,0xC,0x10. Expected: Stall=1 on the fifth. Raise MemReady: 0x0 drains and 0x10 enqueues on the same edge, count stays 4.
- Load priority: 2 entries buffered, MemReady=1, load on 0x20. Expected: MemWrite=0 that cycle; drains resume the next cycle in order 0x0 then 0x4.
- Misalignment: store to 0x6. Expected: Misaligned=1, Stall=0, count unchanged. Load 0x5: ReadDataOut=0, MemRead=0.
- Startin: 3 entries buffered, pulse Startin together with a store. Expected: after the edge Empty=1, the store is discarded, and MemWrite=0 in the Startin cycle.
